range_decoder_front: RTL

RANGE_DECODER_FRONT -- requirements
Module: range_decoder_front

---
 rtl/range_decoder_front_pkg.sv | 28 ++
 rtl/range_decoder_front_div16.sv | 76 +++++++
 rtl/range_decoder_front.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/range_decoder_front_pkg.sv
// Shared definitions for the range decoder front end: FSM state encoding,
// fixed model constants and the symbol-frequency sanity check.
package range_decoder_front_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    DIVIDE = 3'd2,
    LOOKUP = 3'd3,
    UPDATE = 3'd4,
    RENORM = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Total frequency of the probability model, needs 17 bits to hold.
  localparam logic [16:0] TOTAL_FREQ    = 17'h1_0000;
  localparam logic [31:0] RENORM_THRESH = 32'h0100_0000;
  localparam int          INIT_BYTES    = 4;
  localparam int          DIV_STEPS     = 16;

  // A symbol is unusable if it has no width or runs past the top of the model.
  function automatic logic freq_bad(input logic [15:0] low, input logic [15:0] freq);
    logic [16:0] top;
    top = {1'b0, low} + {1'b0, freq};
    return (freq == 16'h0000) || (top > TOTAL_FREQ);
  endfunction

endpackage

// File: rtl/range_decoder_front_div16.sv
// range_div16: restoring divider, 32-bit dividend by 16-bit divisor giving a
// 16-bit quotient. The caller guarantees dividend < divisor<<16, so the
// partial remainder always fits in 16 bits. The first quotient bit is
// produced on the start edge; done is high in the cycle whose edge produces
// the last bit, and quotient then carries the complete result, giving a
// fixed 16-cycle latency from start to a registered result in the caller.
module range_div16
  import range_decoder_front_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);

  localparam logic [4:0] LAST_COUNT = 5'(DIV_STEPS - 1);

  logic [15:0] rem_q;
  logic [15:0] low_q;
  logic [14:0] quo_q;
  logic [15:0] div_q;
  logic [4:0]  count_q;
  logic        active_q;

  logic [15:0] src_rem;
  logic [15:0] src_low;
  logic [14:0] src_quo;
  logic [15:0] src_div;
  logic [16:0] trial;
  logic        take;
  logic [15:0] next_rem;

  // One restoring step, fed from the operands on start or from the registers.
  always_comb begin
    src_rem  = start ? dividend[31:16] : rem_q;
    src_low  = start ? dividend[15:0]  : low_q;
    src_quo  = start ? 15'h0000        : quo_q;
    src_div  = start ? divisor         : div_q;
    trial    = {src_rem, src_low[15]};
    take     = (trial >= {1'b0, src_div});
    next_rem = take ? (trial[15:0] - src_div) : trial[15:0];
    quotient = {src_quo, take};
    done     = active_q && (count_q == 5'd1);
  end

  // Iteration registers; a start while running restarts the division.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      low_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= next_rem;
      low_q    <= {src_low[14:0], 1'b0};
      quo_q    <= quotient[14:0];
      div_q    <= divisor;
      count_q  <= LAST_COUNT;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q   <= next_rem;
      low_q   <= {src_low[14:0], 1'b0};
      quo_q   <= quotient[14:0];
      count_q <= count_q - 5'd1;
      if (count_q == 5'd1) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/range_decoder_front.sv
// range_decoder_front: front end of a range decoder with a fixed total
// frequency of 65536. Loads four code bytes, divides the code offset by the
// scaled range, asks an external table for the symbol, narrows the interval
// and renormalises byte by byte.
// Optional feature: define RANGE_DEC_STATS_EN to add a saturating 32-bit
// symbol_count output.
module range_decoder_front
  import range_decoder_front_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] decoded_range,
  output logic        lookup_en,
  input  logic        lookup_valid,
  input  logic        lookup_error,
  input  logic [15:0] cum_low,
  input  logic [15:0] cum_freq,
  output logic        symbol_done,
  output logic        busy,
  output logic        dec_error
`ifdef RANGE_DEC_STATS_EN
  ,
  output logic [31:0] symbol_count
`endif
);

  state_t      state_q;
  logic [31:0] value_q;
  logic [31:0] range_q;
  logic [1:0]  byte_cnt_q;
  logic [15:0] cum_low_q;
  logic [15:0] cum_freq_q;
  logic [15:0] decoded_range_q;
  logic        div_run_q;
  logic        lookup_en_q;

  logic [15:0] r;
  logic        take_start;
  logic        accept;
  logic        div_overflow;
  logic        div_start;
  logic        div_done;
  logic [15:0] div_quotient;
  logic        upd_bad;
  logic [31:0] prod_low;
  logic [31:0] prod_freq;

  assign r            = range_q[31:16];
  assign take_start   = start && ((state_q == IDLE) || (state_q == ERROR));
  assign accept       = byte_valid && byte_ready;
  assign div_overflow = (value_q >= {r, 16'h0000});
  assign div_start    = (state_q == DIVIDE) && !div_run_q && !div_overflow;
  assign upd_bad      = freq_bad(cum_low_q, cum_freq_q);
  assign prod_low     = {16'h0000, r} * {16'h0000, cum_low_q};
  assign prod_freq    = {16'h0000, r} * {16'h0000, cum_freq_q};

  assign byte_ready    = (state_q == INIT) || ((state_q == RENORM) && (range_q < RENORM_THRESH));
  assign symbol_done   = (state_q == UPDATE) && !upd_bad;
  assign busy          = (state_q != IDLE);
  assign dec_error     = (state_q == ERROR);
  assign lookup_en     = lookup_en_q;
  assign decoded_range = decoded_range_q;

  range_div16 u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (value_q),
    .divisor  (r),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Main decode sequence: code load, divide, table lookup, narrow, renormalise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      value_q         <= '0;
      range_q         <= '0;
      byte_cnt_q      <= '0;
      cum_low_q       <= '0;
      cum_freq_q      <= '0;
      decoded_range_q <= '0;
      div_run_q       <= 1'b0;
      lookup_en_q     <= 1'b0;
    end else begin
      lookup_en_q <= 1'b0;
      if (take_start) begin
        state_q    <= INIT;
        range_q    <= 32'hFFFF_FFFF;
        value_q    <= '0;
        byte_cnt_q <= '0;
        div_run_q  <= 1'b0;
      end else begin
        case (state_q)
          INIT: begin
            if (accept) begin
              value_q    <= {value_q[23:0], byte_in};
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'(INIT_BYTES - 1)) begin
                state_q <= DIVIDE;
              end
            end
          end
          DIVIDE: begin
            if (!div_run_q) begin
              if (div_overflow) begin
                state_q <= ERROR;
              end else begin
                div_run_q <= 1'b1;
              end
            end else if (div_done) begin
              decoded_range_q <= div_quotient;
              div_run_q       <= 1'b0;
              lookup_en_q     <= 1'b1;
              state_q         <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (lookup_error) begin
              state_q <= ERROR;
            end else if (lookup_valid) begin
              cum_low_q  <= cum_low;
              cum_freq_q <= cum_freq;
              state_q    <= UPDATE;
            end
          end
          UPDATE: begin
            if (upd_bad) begin
              state_q <= ERROR;
            end else begin
              value_q <= value_q - prod_low;
              range_q <= prod_freq;
              state_q <= RENORM;
            end
          end
          RENORM: begin
            if (range_q >= RENORM_THRESH) begin
              state_q <= DIVIDE;
            end else if (accept) begin
              range_q <= {range_q[23:0], 8'h00};
              value_q <= {value_q[23:0], byte_in};
            end
          end
          IDLE, ERROR: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef RANGE_DEC_STATS_EN
  // Saturating count of symbols decoded since the last start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      symbol_count <= '0;
    end else if (take_start) begin
      symbol_count <= '0;
    end else if (symbol_done && (symbol_count != 32'hFFFF_FFFF)) begin
      symbol_count <= symbol_count + 32'd1;
    end
  end
`endif

endmodule
